// File: rtl/marker_pkg.sv
// Shared widths, FSM state and marker record for the marker scan controller.
package marker_pkg;

    localparam int X_W   = 11;
    localparam int Y_W   = 10;
    localparam int P_W   = 11;
    localparam int RUN_W = 4;
    localparam logic [RUN_W-1:0] RUN_MAX = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_PUBLISH
    } scan_state_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [P_W-1:0] prob;
    } marker_t;

    function automatic logic [X_W-1:0] abs_diff(input logic [X_W-1:0] a, input logic [X_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/row_best_sel.sv
// Per-row capture of the lowest not-target probability detector hit; cleared at row close.
module row_best_sel
    import marker_pkg::*;
(
    input  logic           clk_in,
    input  logic           rst_n_in,
    input  logic           capture_en,
    input  logic           row_close,
    input  logic           det_done,
    input  logic [X_W-1:0] det_coord,
    input  logic [P_W-1:0] det_prob,
    output logic           row_hit,
    output logic [X_W-1:0] row_x,
    output logic [P_W-1:0] row_prob
);

    // Strict less-than so that an equal-probability later hit never displaces the earlier one.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            row_hit  <= 1'b0;
            row_x    <= '0;
            row_prob <= '0;
        end else if (row_close) begin
            row_hit  <= 1'b0;
            row_prob <= '0;
        end else if (capture_en && det_done && (!row_hit || (det_prob < row_prob))) begin
            row_hit  <= 1'b1;
            row_x    <= det_coord;
            row_prob <= det_prob;
        end
    end

endmodule

// File: rtl/marker_scan_ctrl.sv
// Sequences the row marker detector over each frame and publishes one confirmed marker per frame.
// Define MARKER_SCAN_ROI_EN to add region-of-interest gating of detector hits.
module marker_scan_ctrl
    import marker_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int MIN_ROWS = 4,
    parameter int X_TOL    = 8
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    input  logic [X_W-1:0] hcount_in,
    input  logic [Y_W-1:0] vcount_in,
`ifdef MARKER_SCAN_ROI_EN
    input  logic [X_W-1:0] roi_x0_in,
    input  logic [X_W-1:0] roi_x1_in,
    input  logic [Y_W-1:0] roi_y0_in,
    input  logic [Y_W-1:0] roi_y1_in,
`endif
    output logic           det_rst_out,
    input  logic           det_done_in,
    input  logic [X_W-1:0] det_coord_in,
    input  logic [P_W-1:0] det_prob_in,
    output logic [X_W-1:0] marker_x_out,
    output logic [Y_W-1:0] marker_y_out,
    output logic [P_W-1:0] marker_prob_out,
    output logic           marker_valid_out,
    input  logic           marker_ready_in,
    output logic           overrun_out
);

    localparam logic [X_W-1:0] H_END = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0] V_END = Y_W'(V_ACTIVE);

    scan_state_t      state;
    logic [RUN_W-1:0] run_len;
    logic [RUN_W-1:0] run_len_nxt;
    logic [Y_W-1:0]   run_start;
    logic [Y_W-1:0]   run_start_nxt;
    logic [X_W-1:0]   run_x;
    logic             frame_hit;
    marker_t          frame_best;
    logic [Y_W-1:0]   mid_y;

    logic             row_hit;
    logic             row_hit_eff;
    logic [X_W-1:0]   row_x;
    logic [P_W-1:0]   row_prob;

    logic             roi_ok;
    logic             roi_row_ok;
    logic             scan_active;
    logic             capture_en;
    logic             row_close;
    logic             x_agree;
    logic             take_best;

`ifdef MARKER_SCAN_ROI_EN
    assign roi_row_ok = (vcount_in >= roi_y0_in) && (vcount_in <= roi_y1_in);
    assign roi_ok     = roi_row_ok && (hcount_in >= roi_x0_in) && (hcount_in <= roi_x1_in);
`else
    assign roi_row_ok = 1'b1;
    assign roi_ok     = 1'b1;
`endif

    assign scan_active = (state == ST_SCAN);
    assign capture_en  = scan_active && (hcount_in < H_END) && roi_ok;
    assign row_close   = scan_active && (hcount_in == H_END);
    assign det_rst_out = !scan_active || (hcount_in == '0) || (hcount_in >= H_END);

    row_best_sel u_row_best (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .capture_en(capture_en),
        .row_close (row_close),
        .det_done  (det_done_in),
        .det_coord (det_coord_in),
        .det_prob  (det_prob_in),
        .row_hit   (row_hit),
        .row_x     (row_x),
        .row_prob  (row_prob)
    );

    assign row_hit_eff = row_hit && roi_row_ok;
    assign x_agree     = int'(abs_diff(row_x, run_x)) <= X_TOL;

    // Next run length/start as they will be after this row closes; the frame-best test uses them.
    always_comb begin
        run_len_nxt   = '0;
        run_start_nxt = run_start;
        if (row_hit_eff) begin
            if ((run_len != '0) && x_agree) begin
                run_len_nxt = (run_len == RUN_MAX) ? RUN_MAX : (run_len + RUN_W'(1));
            end else begin
                run_len_nxt   = RUN_W'(1);
                run_start_nxt = vcount_in;
            end
        end
        mid_y     = Y_W'(({1'b0, run_start_nxt} + {1'b0, vcount_in}) >> 1);
        take_best = row_hit_eff && (int'(run_len_nxt) >= MIN_ROWS)
                    && (!frame_hit || (row_prob < frame_best.prob));
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state            <= ST_IDLE;
            run_len          <= '0;
            run_start        <= '0;
            run_x            <= '0;
            frame_hit        <= 1'b0;
            frame_best       <= '0;
            marker_x_out     <= '0;
            marker_y_out     <= '0;
            marker_prob_out  <= '0;
            marker_valid_out <= 1'b0;
            overrun_out      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE:    if ((vcount_in == '0) && (hcount_in == '0)) state <= ST_SCAN;
                ST_SCAN:    if ((vcount_in == V_END) && (hcount_in == '0)) state <= ST_PUBLISH;
                ST_PUBLISH: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase

            if (row_close) begin
                run_len   <= run_len_nxt;
                run_start <= run_start_nxt;
                if (row_hit_eff) begin
                    run_x <= row_x;
                end
                if (take_best) begin
                    frame_hit       <= 1'b1;
                    frame_best.x    <= row_x;
                    frame_best.y    <= mid_y;
                    frame_best.prob <= row_prob;
                end
            end

            // A publish overrides a same-cycle accept: the fresh result stays valid without overrun.
            if ((state == ST_PUBLISH) && frame_hit) begin
                marker_x_out     <= frame_best.x;
                marker_y_out     <= frame_best.y;
                marker_prob_out  <= frame_best.prob;
                marker_valid_out <= 1'b1;
                if (marker_valid_out && !marker_ready_in) begin
                    overrun_out <= 1'b1;
                end
                frame_hit <= 1'b0;
                run_len   <= '0;
            end else if (marker_valid_out && marker_ready_in) begin
                marker_valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_marker_scan_ctrl.sv
// Randomized raster bench for marker_scan_ctrl, checked against a row-level behavioural model.
module tb_marker_scan_ctrl;

    localparam int H_ACTIVE = 16;
    localparam int V_ACTIVE = 12;
    localparam int MIN_ROWS = 4;
    localparam int X_TOL    = 8;
    localparam int H_TOTAL  = 20;
    localparam int V_TOTAL  = 14;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        det_rst_out;
    logic        det_done_in;
    logic [10:0] det_coord_in;
    logic [10:0] det_prob_in;
    logic [10:0] marker_x_out;
    logic [9:0]  marker_y_out;
    logic [10:0] marker_prob_out;
    logic        marker_valid_out;
    logic        marker_ready_in;
    logic        overrun_out;

    always #5 clk_in = ~clk_in;

    marker_scan_ctrl #(
        .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE),
        .MIN_ROWS(MIN_ROWS),
        .X_TOL   (X_TOL)
    ) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .hcount_in       (hcount_in),
        .vcount_in       (vcount_in),
        .det_rst_out     (det_rst_out),
        .det_done_in     (det_done_in),
        .det_coord_in    (det_coord_in),
        .det_prob_in     (det_prob_in),
        .marker_x_out    (marker_x_out),
        .marker_y_out    (marker_y_out),
        .marker_prob_out (marker_prob_out),
        .marker_valid_out(marker_valid_out),
        .marker_ready_in (marker_ready_in),
        .overrun_out     (overrun_out)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int hit_cnt [V_ACTIVE];
    int hit_col [V_ACTIVE][2];
    int hit_x   [V_ACTIVE][2];
    int hit_p   [V_ACTIVE][2];

    int m_len, m_x, m_start;
    bit f_hit;
    int f_x, f_y, f_p;
    bit e_valid, e_over;
    int e_x, e_y, e_p;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed == expected) n_pass++;
        else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    endtask

    function automatic int absInt(input int a);
        return (a < 0) ? -a : a;
    endfunction

    task automatic clearHits();
        for (int r = 0; r < V_ACTIVE; r++) hit_cnt[r] = 0;
    endtask

    task automatic addHit(input int r, input int col, input int x, input int p);
        if (hit_cnt[r] < 2) begin
            hit_col[r][hit_cnt[r]] = col;
            hit_x[r][hit_cnt[r]]   = x;
            hit_p[r][hit_cnt[r]]   = p;
            hit_cnt[r]++;
        end
    endtask

    task automatic addRun(input int r0, input int r1, input int col, input int x, input int p);
        for (int r = r0; r <= r1; r++) addHit(r, col, x, p);
    endtask

    // Hits stay off the last active row so no run is open when the frame closes.
    task automatic randomHits();
        int base, n;
        clearHits();
        base = 100 + $urandom_range(0, 40);
        for (int r = 0; r < V_ACTIVE - 1; r++) begin
            if ($urandom_range(0, 5) == 0) base = base + 30;
            n = $urandom_range(0, 3);
            if (n != 0) addHit(r, $urandom_range(1, 7), base + $urandom_range(0, 12), $urandom_range(0, 15));
            if (n == 3) addHit(r, $urandom_range(8, H_ACTIVE - 1), base + $urandom_range(0, 12), $urandom_range(0, 15));
        end
    endtask

    // Row-by-row application of the qualification rules for one whole frame.
    task automatic modelFrame();
        bit rh;
        int bx, bp;
        f_hit = 1'b0;
        f_x = 0; f_y = 0; f_p = 0;
        for (int r = 0; r < V_ACTIVE; r++) begin
            rh = 1'b0; bx = 0; bp = 0;
            for (int k = 0; k < hit_cnt[r]; k++) begin
                if (!rh || hit_p[r][k] < bp) begin
                    rh = 1'b1; bx = hit_x[r][k]; bp = hit_p[r][k];
                end
            end
            if (!rh) begin
                m_len = 0;
            end else begin
                if (m_len > 0 && absInt(bx - m_x) <= X_TOL) m_len = (m_len < 15) ? m_len + 1 : 15;
                else begin m_len = 1; m_start = r; end
                m_x = bx;
                if (m_len >= MIN_ROWS && (!f_hit || bp < f_p)) begin
                    f_hit = 1'b1; f_x = bx; f_y = (m_start + r) / 2; f_p = bp;
                end
            end
        end
        if (f_hit) m_len = 0;
    endtask

    // mode 0: ready low all frame; 1: ready high all frame; 2: ready high only in the publish cycle.
    task automatic applyStimulus(input int mode, input int rst_row, input int rst_col);
        bit pend_pre, ready_pub, dead, rst_prev;
        bit placed;
        modelFrame();
        pend_pre  = (mode == 1) ? 1'b0 : e_valid;
        ready_pub = (mode != 0);
        dead      = 1'b0;
        rst_prev  = 1'b0;
        for (int v = 0; v < V_TOTAL; v++) begin
            for (int h = 0; h < H_TOTAL; h++) begin
                @(negedge clk_in);
                if (rst_prev) begin
                    checkOutput("rst_valid", marker_valid_out, 0);
                    checkOutput("rst_x", marker_x_out, 0);
                    checkOutput("rst_y", marker_y_out, 0);
                    checkOutput("rst_prob", marker_prob_out, 0);
                    checkOutput("rst_overrun", overrun_out, 0);
                    checkOutput("rst_det_rst", det_rst_out, 1);
                    rst_prev = 1'b0;
                end
                if (v == 2 && h == 1) checkOutput("det_rst_line_start", det_rst_out, 1);
                if (v == 2 && h == 6 && !dead) begin
                    checkOutput("det_rst_active", det_rst_out, 0);
                    checkOutput("mid_valid", marker_valid_out, pend_pre);
                    checkOutput("mid_x_stable", marker_x_out, e_x);
                    checkOutput("mid_y_stable", marker_y_out, e_y);
                    checkOutput("mid_prob_stable", marker_prob_out, e_p);
                    checkOutput("mid_overrun", overrun_out, e_over);
                end
                if (v == 3 && h == H_ACTIVE + 1) checkOutput("det_rst_row_close", det_rst_out, 1);
                if (v == V_ACTIVE && h == 1) checkOutput("valid_before_publish", marker_valid_out, dead ? 0 : pend_pre);
                if (v == V_ACTIVE && h == 2) begin
                    if (!dead) begin
                        if (f_hit) begin
                            e_over  = e_over | (pend_pre & !ready_pub);
                            e_x = f_x; e_y = f_y; e_p = f_p;
                            e_valid = 1'b1;
                        end else begin
                            e_valid = pend_pre & !ready_pub;
                        end
                    end
                    checkOutput("pub_valid", marker_valid_out, e_valid);
                    checkOutput("pub_x", marker_x_out, e_x);
                    checkOutput("pub_y", marker_y_out, e_y);
                    checkOutput("pub_prob", marker_prob_out, e_p);
                    checkOutput("pub_overrun", overrun_out, e_over);
                    if (mode == 1) e_valid = 1'b0;
                end
                hcount_in       = 11'(h);
                vcount_in       = 10'(v);
                marker_ready_in = (mode == 1) || (mode == 2 && v == V_ACTIVE && h == 1);
                placed = 1'b0;
                if (v < V_ACTIVE) begin
                    for (int k = 0; k < hit_cnt[v]; k++) begin
                        if (hit_col[v][k] == h) begin
                            det_done_in  = 1'b1;
                            det_coord_in = 11'(hit_x[v][k]);
                            det_prob_in  = 11'(hit_p[v][k]);
                            placed = 1'b1;
                        end
                    end
                end
                if (!placed) begin
                    det_done_in  = 1'b0;
                    det_coord_in = 11'($urandom_range(0, 2047));
                    det_prob_in  = 11'($urandom_range(0, 2047));
                end
                if (v == rst_row && h == rst_col) begin
                    rst_n_in = 1'b0;
                    rst_prev = 1'b1;
                    dead     = 1'b1;
                    e_valid = 1'b0; e_over = 1'b0;
                    e_x = 0; e_y = 0; e_p = 0;
                    m_len = 0; m_x = 0; m_start = 0;
                end else begin
                    rst_n_in = 1'b1;
                end
            end
        end
    endtask

    initial begin
        rst_n_in        = 1'b0;
        hcount_in       = 11'(H_TOTAL - 1);
        vcount_in       = 10'(V_TOTAL - 1);
        det_done_in     = 1'b0;
        det_coord_in    = '0;
        det_prob_in     = '0;
        marker_ready_in = 1'b0;
        repeat (3) @(negedge clk_in);
        checkOutput("reset_valid", marker_valid_out, 0);
        checkOutput("reset_x", marker_x_out, 0);
        checkOutput("reset_y", marker_y_out, 0);
        checkOutput("reset_prob", marker_prob_out, 0);
        checkOutput("reset_overrun", overrun_out, 0);
        checkOutput("reset_det_rst", det_rst_out, 1);
        e_valid = 1'b0; e_over = 1'b0; e_x = 0; e_y = 0; e_p = 0;
        m_len = 0; m_x = 0; m_start = 0;

        clearHits(); addRun(3, 8, 7, 10, 5);                          applyStimulus(1, -1, -1);
        clearHits(); addRun(2, 4, 7, 30, 4);                          applyStimulus(1, -1, -1);
        clearHits(); addRun(1, 4, 5, 20, 6); addRun(5, 8, 5, 40, 7);  applyStimulus(1, -1, -1);
        clearHits(); addRun(0, 3, 9, 50, 9); addRun(5, 8, 9, 60, 3);  applyStimulus(1, -1, -1);
        clearHits(); addRun(0, 3, 9, 50, 3); addRun(5, 8, 9, 60, 3);  applyStimulus(1, -1, -1);
        clearHits(); addRun(1, 5, 4, 70, 8); addHit(3, 12, 72, 2);    applyStimulus(1, -1, -1);
        clearHits(); addRun(2, 6, 3, 80, 4);                          applyStimulus(0, -1, -1);
        clearHits(); addRun(4, 9, 3, 90, 2);                          applyStimulus(2, -1, -1);
        clearHits(); addRun(1, 7, 3, 95, 1);                          applyStimulus(0, -1, -1);
        clearHits();                                                  applyStimulus(1, -1, -1);
        clearHits(); addRun(1, 9, 6, 33, 5);                          applyStimulus(0, 6, 3);
        clearHits(); addRun(1, 9, 6, 44, 5);                          applyStimulus(1, -1, -1);

        for (int i = 0; i < 30; i++) begin
            randomHits();
            if (i == 15) applyStimulus($urandom_range(0, 2), $urandom_range(4, V_ACTIVE - 1), $urandom_range(0, H_TOTAL - 1));
            else         applyStimulus($urandom_range(0, 2), -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
